// File: rtl/msort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msort_pkg
// Description : Shared types and helpers for the streaming merge sorter:
//               FSM state encoding, clog2 helper and block-depth derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package msort_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SORT  = 2'd2,
        ST_DRAIN = 2'd3
    } msort_state_t;

    localparam int MSORT_DATA_W_DEF = 8;
    localparam int MSORT_LANES_DEF  = 4;
    localparam int MSORT_BEATS_DEF  = 2;
    localparam int MSORT_DEPTH_DEF  = MSORT_LANES_DEF * MSORT_BEATS_DEF;

    // Bits needed to count 0..v-1, never less than one bit.
    function automatic int msort_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Number of buffer entries in one block.
    function automatic int msort_depth(input int lanes, input int beats);
        return lanes * beats;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msort_cmp_swap.sv
`default_nettype none
// ============================================================================
// Module      : msort_cmp_swap
// Description : Combinational signed compare-exchange cell. 'lo' feeds the
//               lower buffer index, 'hi' the upper one. Ascending keeps the
//               smaller value low; descending keeps the larger value low.
// Revision    : 1.0 - initial release
// ============================================================================
module msort_cmp_swap
    import msort_pkg::*;
#(
    parameter int DATA_W = MSORT_DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     descend,
    output logic signed [DATA_W-1:0] lo,
    output logic signed [DATA_W-1:0] hi,
    output logic                     swapped
);

    // Exchange only when the pair is out of order for the requested direction.
    always_comb begin
        swapped = descend ? (a < b) : (a > b);
        lo      = swapped ? b : a;
        hi      = swapped ? a : b;
    end

endmodule
`default_nettype wire

// File: rtl/merge_sort_stream.sv
`default_nettype none
// ============================================================================
// Module      : merge_sort_stream
// Description : Collects BEATS beats of LANES signed samples, sorts the block
//               in place with a sequential odd-even transposition network and
//               streams it out one sample per cycle under valid/ready.
//               Optional macro MSORT_EARLY_EXIT_EN: stop sorting after two
//               consecutive phases without any exchange.
// Revision    : 1.0 - initial release
// ============================================================================
module merge_sort_stream
    import msort_pkg::*;
#(
    parameter int DATA_W = MSORT_DATA_W_DEF,
    parameter int LANES  = MSORT_LANES_DEF,
    parameter int BEATS  = MSORT_BEATS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      BlkIn,
    input  logic [LANES*DATA_W-1:0]   InData,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic                      Descend,
    output logic signed [DATA_W-1:0]  SortOut,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic                      OutLast,
    output logic                      Busy
);

    localparam int DEPTH = msort_depth(LANES, BEATS);
    localparam int BCW   = msort_clog2(BEATS);
    localparam int PCW   = msort_clog2(DEPTH);
    localparam int NE    = DEPTH / 2;          // even-phase pairs
    localparam int NO    = (DEPTH - 1) / 2;    // odd-phase pairs
    localparam int NO_SZ = (NO > 0) ? NO : 1;

    msort_state_t             state;
    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [BCW-1:0]           beat_cnt;
    logic [PCW-1:0]           phase;
    logic [PCW-1:0]           rd_idx;
    logic [PCW-1:0]           rd_next;
    logic                     descend_q;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_last;
    logic signed [DATA_W-1:0] sort_out;
    logic                     busy;
    int                       wr_beat;
    logic                     sort_done;

    logic signed [DATA_W-1:0] even_lo [NE];
    logic signed [DATA_W-1:0] even_hi [NE];
    logic signed [DATA_W-1:0] odd_lo  [NO_SZ];
    logic signed [DATA_W-1:0] odd_hi  [NO_SZ];
    logic signed [DATA_W-1:0] phase_next [DEPTH];
`ifdef MSORT_EARLY_EXIT_EN
    logic [NE-1:0]            even_sw;
    logic [NO_SZ-1:0]         odd_sw;
    logic                     phase_swap;
    logic                     prev_noswap;
`endif

    // Even-phase cells: pairs (0,1),(2,3),...
    for (genvar gi = 0; gi < NE; gi++) begin : g_even
        msort_cmp_swap #(.DATA_W(DATA_W)) u_cell (
            .a       (mem[2*gi]),
            .b       (mem[2*gi+1]),
            .descend (descend_q),
            .lo      (even_lo[gi]),
            .hi      (even_hi[gi]),
`ifdef MSORT_EARLY_EXIT_EN
            .swapped (even_sw[gi])
`else
            .swapped ()
`endif
        );
    end

    // Odd-phase cells: pairs (1,2),(3,4),...; none exist for a 2-entry block.
    if (NO > 0) begin : g_odd
        for (genvar gj = 0; gj < NO; gj++) begin : g_cell
            msort_cmp_swap #(.DATA_W(DATA_W)) u_cell (
                .a       (mem[2*gj+1]),
                .b       (mem[2*gj+2]),
                .descend (descend_q),
                .lo      (odd_lo[gj]),
                .hi      (odd_hi[gj]),
`ifdef MSORT_EARLY_EXIT_EN
                .swapped (odd_sw[gj])
`else
                .swapped ()
`endif
            );
        end
    end else begin : g_odd_none
        assign odd_lo[0] = '0;
        assign odd_hi[0] = '0;
`ifdef MSORT_EARLY_EXIT_EN
        assign odd_sw    = '0;
`endif
    end

    // Buffer contents after the current phase's compare-exchanges.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) phase_next[j] = mem[j];
        if (!phase[0]) begin
            for (int i = 0; i < NE; i++) begin
                phase_next[2*i]   = even_lo[i];
                phase_next[2*i+1] = even_hi[i];
            end
        end else begin
            for (int i = 0; i < NO; i++) begin
                phase_next[2*i+1] = odd_lo[i];
                phase_next[2*i+2] = odd_hi[i];
            end
        end
    end

    // Sort termination: phase limit, or two quiet phases in a row when enabled.
    always_comb begin
        sort_done = (int'(phase) == DEPTH - 1);
`ifdef MSORT_EARLY_EXIT_EN
        phase_swap = phase[0] ? (|odd_sw) : (|even_sw);
        if (!phase_swap && prev_noswap) sort_done = 1'b1;
`endif
    end

    // Beat slot being written and the next read index.
    always_comb begin
        wr_beat = (state == ST_LOAD && !BlkIn) ? int'(beat_cnt) : 0;
        rd_next = rd_idx + 1'b1;
    end

    // Main controller: load, sort, drain with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
            beat_cnt  <= '0;
            phase     <= '0;
            rd_idx    <= '0;
            descend_q <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sort_out  <= '0;
            busy      <= 1'b0;
`ifdef MSORT_EARLY_EXIT_EN
            prev_noswap <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (InValid && in_ready && BlkIn) begin
                        for (int j = 0; j < DEPTH; j++)
                            if (j / LANES == wr_beat) mem[j] <= InData[(j % LANES)*DATA_W +: DATA_W];
                        descend_q <= Descend;
                        beat_cnt  <= BCW'(1);
                        busy      <= 1'b1;
                        if (BEATS == 1) begin
                            state    <= ST_SORT;
                            in_ready <= 1'b0;
                            phase    <= '0;
`ifdef MSORT_EARLY_EXIT_EN
                            prev_noswap <= 1'b0;
`endif
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (InValid && in_ready) begin
                        for (int j = 0; j < DEPTH; j++)
                            if (j / LANES == wr_beat) mem[j] <= InData[(j % LANES)*DATA_W +: DATA_W];
                        if (BlkIn) begin
                            descend_q <= Descend;
                            beat_cnt  <= BCW'(1);
                        end else if (int'(beat_cnt) == BEATS - 1) begin
                            state    <= ST_SORT;
                            in_ready <= 1'b0;
                            phase    <= '0;
                            beat_cnt <= '0;
`ifdef MSORT_EARLY_EXIT_EN
                            prev_noswap <= 1'b0;
`endif
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_SORT: begin
                    for (int j = 0; j < DEPTH; j++) mem[j] <= phase_next[j];
`ifdef MSORT_EARLY_EXIT_EN
                    prev_noswap <= !phase_swap;
`endif
                    if (sort_done) begin
                        state     <= ST_DRAIN;
                        out_valid <= 1'b1;
                        out_last  <= 1'b0;
                        sort_out  <= phase_next[0];
                        rd_idx    <= '0;
                        phase     <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (OutReady) begin
                        if (out_last) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            sort_out  <= '0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            rd_idx    <= '0;
                        end else begin
                            rd_idx   <= rd_next;
                            sort_out <= mem[rd_next];
                            out_last <= (int'(rd_next) == DEPTH - 1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign InReady  = in_ready;
    assign OutValid = out_valid;
    assign OutLast  = out_last;
    assign SortOut  = sort_out;
    assign Busy     = busy;

endmodule
`default_nettype wire
